// File: rtl/dlmac_job_sched.sv
// Job scheduler sharing one DLFloat16 MAC between two requesters, round-robin at job boundaries.
// Optional stall watchdog enabled by defining DLMAC_SCHED_TIMEOUT_EN.
module dlmac_job_sched #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req0_last,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic             req1_last,
  output logic             res0_valid,
  input  logic             res0_ready,
  output logic             res1_valid,
  input  logic             res1_ready,
  output logic [15:0]      res_data,
  output logic [LEN_W-1:0] res_cnt,
  output logic             res_err,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_vld,
  output logic             mac_clr,
  input  logic [15:0]      mac_acc
);

  localparam int DRN_W = $clog2(MAC_LAT + 2) + 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MAC_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_STREAM, S_DRAIN, S_RESP} state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [15:0]      mac_a_q, mac_a_d;
  logic [15:0]      mac_b_q, mac_b_d;
  logic             mac_vld_q, mac_vld_d;
  logic [15:0]      res_data_q, res_data_d;
`ifdef DLMAC_SCHED_TIMEOUT_EN
  logic [7:0]       idle_q, idle_d;
  logic             err_q, err_d;
`endif

  logic        sel_valid, sel_last, sel_res_ready, hs;
  logic [15:0] sel_a, sel_b;

  assign sel_valid     = grant_q ? req1_valid : req0_valid;
  assign sel_last      = grant_q ? req1_last  : req0_last;
  assign sel_a         = grant_q ? req1_a     : req0_a;
  assign sel_b         = grant_q ? req1_b     : req0_b;
  assign sel_res_ready = grant_q ? res1_ready : res0_ready;
  assign hs            = (state_q == S_STREAM) && sel_valid;

  assign req0_ready = (state_q == S_STREAM) && !grant_q;
  assign req1_ready = (state_q == S_STREAM) &&  grant_q;
  assign res0_valid = (state_q == S_RESP)   && !grant_q;
  assign res1_valid = (state_q == S_RESP)   &&  grant_q;
  assign mac_clr    = (state_q == S_CLR);
  assign mac_vld    = mac_vld_q;
  assign mac_a      = mac_a_q;
  assign mac_b      = mac_b_q;
  assign res_data   = res_data_q;
  assign res_cnt    = cnt_q;
`ifdef DLMAC_SCHED_TIMEOUT_EN
  assign res_err    = err_q;
`else
  assign res_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      drn_q        <= '0;
      mac_a_q      <= '0;
      mac_b_q      <= '0;
      mac_vld_q    <= 1'b0;
      res_data_q   <= '0;
`ifdef DLMAC_SCHED_TIMEOUT_EN
      idle_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      drn_q        <= drn_d;
      mac_a_q      <= mac_a_d;
      mac_b_q      <= mac_b_d;
      mac_vld_q    <= mac_vld_d;
      res_data_q   <= res_data_d;
`ifdef DLMAC_SCHED_TIMEOUT_EN
      idle_q       <= idle_d;
      err_q        <= err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    drn_d        = drn_q;
    mac_a_d      = mac_a_q;
    mac_b_d      = mac_b_q;
    mac_vld_d    = 1'b0;
    res_data_d   = res_data_q;
`ifdef DLMAC_SCHED_TIMEOUT_EN
    idle_d       = idle_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // On contention the requester that did not run last job wins.
        if (req0_valid || req1_valid) begin
          grant_d = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        state_d = S_STREAM;
`ifdef DLMAC_SCHED_TIMEOUT_EN
        idle_d  = '0;
        err_d   = 1'b0;
`endif
      end
      S_STREAM: begin
        if (hs) begin
          mac_a_d   = sel_a;
          mac_b_d   = sel_b;
          mac_vld_d = 1'b1;
          cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`ifdef DLMAC_SCHED_TIMEOUT_EN
          idle_d    = '0;
`endif
          if (sel_last) begin
            state_d      = S_DRAIN;
            drn_d        = '0;
            last_grant_d = grant_q;
          end
        end else begin
`ifdef DLMAC_SCHED_TIMEOUT_EN
          if (idle_q == 8'hFF) begin
            state_d      = S_DRAIN;
            drn_d        = '0;
            err_d        = 1'b1;
            last_grant_d = grant_q;
          end else begin
            idle_d = idle_q + 8'd1;
          end
`endif
        end
      end
      S_DRAIN: begin
        // Wait for the last product to land in the accumulator before sampling it.
        drn_d = drn_q + 1'b1;
        if (drn_q == DRN_LAST) begin
          state_d = S_RESP;
`ifdef DLMAC_SCHED_TIMEOUT_EN
          res_data_d = err_q ? 16'hFFFF : mac_acc;
`else
          res_data_d = mac_acc;
`endif
        end
      end
      S_RESP: begin
        if (sel_res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dlmac_job_sched.sv
// Scoreboard bench for dlmac_job_sched with a behavioural DLFloat16 MAC model.
module tb_dlmac_job_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_last, req1_valid, req1_last;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        res0_valid, res1_valid, res0_ready, res1_ready;
  logic [15:0] res_data;
  logic [7:0]  res_cnt;
  logic        res_err;
  logic [15:0] mac_a, mac_b, mac_acc;
  logic        mac_vld, mac_clr;

  dlmac_job_sched #(.LEN_W(8), .MAC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_last(req1_last),
    .res0_valid(res0_valid), .res0_ready(res0_ready), .res1_valid(res1_valid), .res1_ready(res1_ready),
    .res_data(res_data), .res_cnt(res_cnt), .res_err(res_err),
    .mac_a(mac_a), .mac_b(mac_b), .mac_vld(mac_vld), .mac_clr(mac_clr), .mac_acc(mac_acc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [15:0] data;
    logic [7:0]  cnt;
    logic        err;
  } res_t;

  res_t        exp_q[$];
  logic [31:0] op_q[$];
  int checks = 0;
  int failures = 0;
  int clr_cnt = 0;
  int vld_cnt = 0;
  int vld_last = 0;
  int vld_prev = 0;
  int r1_viol = 0;
  bit watch_r1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic real d2r(input logic [15:0] d);
    real m;
    int  e;
    if (d[14:0] == 15'd0) return 0.0;
    m = 1.0 + real'(d[8:0]) / 512.0;
    e = int'(d[14:9]) - 31;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return d[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2d(input real r);
    logic       s;
    int         e;
    real        m;
    logic [8:0] f;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 31;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = 9'($rtoi((m - 1.0) * 512.0));
    return {s, 6'(e), f};
  endfunction

  // MAC model: one pipeline stage then the accumulator, cleared only by mac_clr.
  real  acc_r = 0.0;
  real  s1_p  = 0.0;
  logic s1_v  = 1'b0;
  int   cyc   = 0;
  assign mac_acc = r2d(acc_r);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_clr) begin
      acc_r <= 0.0;
      s1_v  <= 1'b0;
    end else begin
      if (s1_v) acc_r <= acc_r + s1_p;
      s1_v <= mac_vld;
      s1_p <= d2r(mac_a) * d2r(mac_b);
    end
  end

  function automatic logic [63:0] outs();
    return {1'b0, req0_ready, req1_ready, res0_valid, res1_valid, res_data, res_cnt,
            res_err, mac_a, mac_b, mac_vld, mac_clr};
  endfunction

  // Monitor: operand scoreboard on mac_vld, result scoreboard on result handshakes.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (mac_clr) clr_cnt++;
      if (mac_vld) begin
        vld_cnt++;
        vld_prev = vld_last;
        vld_last = cyc;
        if (op_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_mac_vld: got a=%0h b=%0h expected no operands", mac_a, mac_b);
        end else begin
          logic [31:0] e;
          e = op_q.pop_front();
          chk("mac_a", mac_a, e[31:16]);
          chk("mac_b", mac_b, e[15:0]);
        end
      end
      if ((res0_valid && res0_ready) || (res1_valid && res1_ready)) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result: got data=%0h expected no result", res_data);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("res_requester", res1_valid, e.req);
          chk("res_data", res_data, e.data);
          chk("res_cnt", res_cnt, e.cnt);
          chk("res_err", res_err, e.err);
        end
        if (res0_valid) watch_r1 = 0;
      end
      if (watch_r1 && req1_ready) r1_viol++;
    end
  end

  task automatic send_pair(input bit r, input logic [15:0] a, input logic [15:0] b, input bit lst);
    int t;
    bit got;
    t = 0;
    got = 0;
    if (r) begin req1_a = a; req1_b = b; req1_last = lst; req1_valid = 1'b1; end
    else   begin req0_a = a; req0_b = b; req0_last = lst; req0_valid = 1'b1; end
    while (!got && t < 3000) begin
      @(negedge clk);
      t++;
      if (r ? req1_ready : req0_ready) begin
        @(posedge clk);
        got = 1;
        op_q.push_back({a, b});
      end
    end
    #1;
    if (r) begin req1_valid = 1'b0; req1_last = 1'b0; end
    else   begin req0_valid = 1'b0; req0_last = 1'b0; end
    if (!got) chk("handshake_timeout", got, 1);
  endtask

  task automatic run_job(input bit r, input int n, input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < n; i++) send_pair(r, a, b, i == n - 1);
  endtask

  task automatic wait_drain(input int max);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || op_q.size() != 0) && t < max) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending_results", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base_clr, base_vld, n, t;
    bit ok;
    rst_n = 1'b0;
    req0_valid = 0; req0_last = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_last = 0; req1_a = 0; req1_b = 0;
    res0_ready = 1; res1_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention after reset: req0 first, req1 blocked until req0's result is taken.
    exp_q.push_back('{req: 1'b0, data: 16'h4000, cnt: 8'd1, err: 1'b0});
    exp_q.push_back('{req: 1'b1, data: 16'h4400, cnt: 8'd2, err: 1'b0});
    watch_r1 = 1;
    fork
      run_job(0, 1, 16'h3E00, 16'h4000);
      run_job(1, 2, 16'h4000, 16'h4000);
    join
    wait_drain(2000);
    chk("req1_ready_during_req0_job", r1_viol, 0);

    // Single job: 3 x (1.0*1.0) = 3.0, one clear, three MAC pulses, result 4 cycles after last.
    base_clr = clr_cnt;
    base_vld = vld_cnt;
    exp_q.push_back('{req: 1'b0, data: 16'h4100, cnt: 8'd3, err: 1'b0});
    run_job(0, 3, 16'h3E00, 16'h3E00);
    n = 0;
    ok = 0;
    while (!ok && n < 50) begin
      @(posedge clk); n++; #1;
      if (res0_valid) ok = 1;
    end
    chk("result_latency", n, 4);
    wait_drain(2000);
    chk("single_clr_pulses", clr_cnt - base_clr, 1);
    chk("single_vld_pulses", vld_cnt - base_vld, 3);

    // Second contention: req0 ran last, so req1 wins.
    exp_q.push_back('{req: 1'b1, data: 16'h3E00, cnt: 8'd1, err: 1'b0});
    exp_q.push_back('{req: 1'b0, data: 16'h4000, cnt: 8'd1, err: 1'b0});
    fork
      run_job(0, 1, 16'h4000, 16'h3E00);
      run_job(1, 1, 16'h3E00, 16'h3E00);
    join
    wait_drain(2000);

    // Backpressure on req1's result while req0 is waiting for a grant.
    exp_q.push_back('{req: 1'b1, data: 16'h4200, cnt: 8'd2, err: 1'b0});
    exp_q.push_back('{req: 1'b0, data: 16'h3E00, cnt: 8'd1, err: 1'b0});
    res1_ready = 0;
    run_job(1, 2, 16'h3E00, 16'h4000);
    fork
      run_job(0, 1, 16'h3E00, 16'h3E00);
    join_none
    t = 0;
    ok = 0;
    while (!ok && t < 50) begin
      @(negedge clk); t++;
      if (res1_valid) ok = 1;
    end
    chk("bp_result_seen", ok, 1);
    chk("bp_data", res_data, 16'h4200);
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (!(res1_valid && res_data == 16'h4200 && res_cnt == 8'd2 &&
            !req0_ready && !mac_clr && !res0_valid)) ok = 0;
    end
    chk("bp_hold_stable", ok, 1);
    @(posedge clk); #1;
    res1_ready = 1;
    wait fork;
    wait_drain(2000);

    // Stalled stream: 5 idle cycles between the two pairs.
    exp_q.push_back('{req: 1'b0, data: 16'h4000, cnt: 8'd2, err: 1'b0});
    send_pair(0, 16'h3E00, 16'h3E00, 0);
    repeat (5) @(posedge clk);
    #1;
    send_pair(0, 16'h3E00, 16'h3E00, 1);
    wait_drain(2000);
    chk("stall_vld_spacing", vld_last - vld_prev, 6);

    // Special operand values pass through untouched.
    exp_q.push_back('{req: 1'b0, data: 16'h0000, cnt: 8'd2, err: 1'b0});
    run_job(0, 2, 16'hFFFF, 16'h0000);
    exp_q.push_back('{req: 1'b0, data: 16'h0000, cnt: 8'd1, err: 1'b0});
    run_job(0, 1, 16'h0000, 16'hFFFF);
    wait_drain(2000);

    // Pair counter saturates at 255.
    exp_q.push_back('{req: 1'b0, data: 16'h0000, cnt: 8'hFF, err: 1'b0});
    run_job(0, 257, 16'h0000, 16'h0000);
    wait_drain(2000);

    // Reset in the middle of a job.
    send_pair(0, 16'h3E00, 16'h3E00, 0);
    send_pair(0, 16'h3E00, 16'h3E00, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base_clr = clr_cnt;
    exp_q.push_back('{req: 1'b1, data: 16'h3E00, cnt: 8'd1, err: 1'b0});
    run_job(1, 1, 16'h3E00, 16'h3E00);
    wait_drain(2000);
    chk("post_reset_clr_pulses", clr_cnt - base_clr, 1);

`ifdef DLMAC_SCHED_TIMEOUT_EN
    // Watchdog: one pair then a stalled requester.
    exp_q.push_back('{req: 1'b0, data: 16'hFFFF, cnt: 8'd1, err: 1'b1});
    send_pair(0, 16'h3E00, 16'h3E00, 0);
    wait_drain(2000);
`endif

    chk("leftover_operands", op_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
